// File: rtl/dsi_pkg.sv
// Shared types for the DSI lane distributor: lane-count type, FSM states, lane-mask helper.
package dsi_pkg;
    localparam int MAX_LANES = 4;

    typedef logic [1:0] lane_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_STREAM,
        ST_DRAIN
    } dsi_state_t;

    function automatic logic [MAX_LANES-1:0] lane_mask_of(lane_cnt_t n_m1);
        logic [4:0] m;
        m = (5'd2 << n_m1) - 5'd1;
        return m[MAX_LANES-1:0];
    endfunction
endpackage

// File: rtl/dsi_lane_distributor_if.sv
// Packet word stream in, per-lane byte/control bus out.
// master = packet source plus lane PHYs; slave = distributor.
interface dsi_lane_distributor_if;
    logic [1:0]  lanes_number;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_data;
    logic        pkt_last;
    logic [1:0]  pkt_bytes;
    logic        pkt_mode_lp;
    logic [3:0]  lane_start_rqst;
    logic [3:0]  lane_fin_rqst;
    logic [31:0] lane_data;
    logic        lane_mode_lp;
    logic [3:0]  lane_data_rqst;
    logic [3:0]  lane_active;

    modport master (
        output lanes_number, pkt_valid, pkt_data, pkt_last, pkt_bytes, pkt_mode_lp,
        output lane_data_rqst, lane_active,
        input  pkt_ready, lane_start_rqst, lane_fin_rqst, lane_data, lane_mode_lp
    );

    modport slave (
        input  lanes_number, pkt_valid, pkt_data, pkt_last, pkt_bytes, pkt_mode_lp,
        input  lane_data_rqst, lane_active,
        output pkt_ready, lane_start_rqst, lane_fin_rqst, lane_data, lane_mode_lp
    );
endinterface

// File: rtl/dsi_lane_byte_fifo.sv
// Per-lane {last, byte} FIFO; head is visible combinationally, one-cycle write latency.
// Caller never pushes when full unless popping in the same cycle; never pops when empty.
module dsi_lane_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wptr] <= din;
    end
endmodule

// File: rtl/dsi_lane_distributor.sv
// Stripes DSI packet bytes round-robin over 1..4 lanes via per-lane FIFOs; LP packets use lane 0.
// Start pulse once every lane FIFO is full or holds its final byte; pkt_ready drops while the target FIFO is full.
module dsi_lane_distributor
    import dsi_pkg::*;
#(
    parameter int MAX_LANES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    dsi_lane_distributor_if.slave bus,
    output logic                  busy,
    output logic                  underrun
);
    dsi_state_t state, state_nxt;
    lane_cnt_t  n_m1, lane_ptr;
    logic [MAX_LANES-1:0] mask, lane_busy, got_last, full, empty, push, pop, fin_head;
    logic [8:0]  head [MAX_LANES];
    logic [31:0] lane_data_w, cur_dat, nxt_dat, cur_sh;
    logic        mode_lp, cur_vld, nxt_vld, cur_last, nxt_last, pkt_done;
    logic [1:0]  cur_bytes, nxt_bytes, bptr, cur_nbytes;
    logic [3:0]  rem_after;
    logic        unpack_en, byte_avail, move, cur_end, pkt_end, nxt_to_cur, last_held;
    logic        accept, byte_last;

    // Two word registers: a byte of cur can only be tagged once the following word
    // (or the knowledge that cur is the last word) tells how many bytes remain.
    assign unpack_en  = (state == ST_LOAD) || (state == ST_START) || (state == ST_STREAM);
    assign cur_nbytes = cur_last ? cur_bytes : 2'd3;
    assign byte_avail = cur_vld && (cur_last || nxt_vld);
    assign move       = unpack_en && byte_avail && (!full[lane_ptr] || pop[lane_ptr]);
    assign cur_end    = move && (bptr == cur_nbytes);
    assign pkt_end    = cur_end && cur_last;
    assign nxt_to_cur = nxt_vld && (!cur_vld || cur_end);
    assign last_held  = (cur_vld && cur_last) || (nxt_vld && nxt_last);
    assign bus.pkt_ready = unpack_en && !pkt_done && !last_held && (!nxt_vld || nxt_to_cur);
    assign accept     = bus.pkt_valid && bus.pkt_ready;
    assign cur_sh     = cur_dat >> {bptr, 3'b000};

    always_comb begin
        rem_after = {2'b00, 2'(cur_nbytes - bptr)};
        if (!cur_last) rem_after = rem_after + (nxt_last ? ({2'b00, nxt_bytes} + 4'd1) : 4'd4);
    end
    assign byte_last = (rem_after <= {2'b00, n_m1});

    always_comb begin
        lane_data_w = '0;
        push        = '0;
        pop         = '0;
        fin_head    = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            lane_data_w[8*k +: 8] = empty[k] ? 8'h00 : head[k][7:0];
            fin_head[k] = !empty[k] && head[k][8];
            pop[k]      = bus.lane_data_rqst[k] && lane_busy[k] && !empty[k];
            push[k]     = move && (lane_ptr == lane_cnt_t'(k));
        end
    end

    for (genvar k = 0; k < MAX_LANES; k++) begin : g_lane
        dsi_lane_byte_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_sys (clk_sys),
            .rst_n   (rst_n),
            .push    (push[k]),
            .pop     (pop[k]),
            .din     ({byte_last, cur_sh[7:0]}),
            .full    (full[k]),
            .empty   (empty[k]),
            .head    (head[k])
        );
    end

    assign bus.lane_data       = lane_data_w;
    assign bus.lane_fin_rqst   = fin_head;
    assign bus.lane_start_rqst = (state == ST_START) ? mask : '0;
    assign bus.lane_mode_lp    = mode_lp;
    assign busy                = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.pkt_valid) state_nxt = ST_LOAD;
            ST_LOAD:   if (((bus.lane_active & mask) == '0) && (&(full | got_last | ~mask)))
                           state_nxt = ST_START;
            ST_START:  state_nxt = ST_STREAM;
            ST_STREAM: if ((lane_busy & mask) == '0) state_nxt = ST_DRAIN;
            ST_DRAIN:  if ((bus.lane_active & mask) == '0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            n_m1      <= '0;
            mask      <= '0;
            mode_lp   <= 1'b0;
            lane_busy <= '0;
            got_last  <= '0;
            underrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.pkt_valid) begin
                n_m1    <= bus.pkt_mode_lp ? 2'd0 : bus.lanes_number;
                mask    <= lane_mask_of(bus.pkt_mode_lp ? 2'd0 : bus.lanes_number);
                mode_lp <= bus.pkt_mode_lp;
            end
            if (state == ST_IDLE) got_last <= '0;
            else                  got_last <= got_last | (push & {MAX_LANES{byte_last}});
            if (state == ST_START) begin
                lane_busy <= mask;
                underrun  <= 1'b0;
            end else begin
                lane_busy <= lane_busy & ~(pop & fin_head);
                if (|(bus.lane_data_rqst & lane_busy & empty)) underrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cur_vld <= 1'b0; cur_dat <= '0; cur_last <= 1'b0; cur_bytes <= '0;
            nxt_vld <= 1'b0; nxt_dat <= '0; nxt_last <= 1'b0; nxt_bytes <= '0;
            bptr    <= '0;   lane_ptr <= '0; pkt_done <= 1'b0;
        end else if (state == ST_IDLE) begin
            cur_vld <= 1'b0; nxt_vld <= 1'b0;
            bptr    <= '0;   lane_ptr <= '0; pkt_done <= 1'b0;
        end else begin
            if (move) begin
                bptr     <= cur_end ? 2'd0 : bptr + 2'd1;
                lane_ptr <= (lane_ptr == n_m1) ? 2'd0 : lane_ptr + 2'd1;
            end
            if (pkt_end) pkt_done <= 1'b1;
            if (nxt_to_cur) begin
                cur_vld   <= 1'b1;
                cur_dat   <= nxt_dat;
                cur_last  <= nxt_last;
                cur_bytes <= nxt_bytes;
            end else if (cur_end) begin
                cur_vld <= 1'b0;
            end
            if (accept) begin
                nxt_vld   <= 1'b1;
                nxt_dat   <= bus.pkt_data;
                nxt_last  <= bus.pkt_last;
                nxt_bytes <= bus.pkt_last ? bus.pkt_bytes : 2'd3;
            end else if (nxt_to_cur) begin
                nxt_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Scoreboard bench: packets push expected per-lane {fin, byte} entries and start masks;
// a negedge monitor compares every lane pop and start pulse against them.
module tb_dsi_lane_distributor;
    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    logic busy, underrun;

    dsi_lane_distributor_if bus();

    dsi_lane_distributor #(.MAX_LANES(4), .FIFO_DEPTH(4)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int rq_period = 1;
    int cyc = 0;
    int stall_cnt = 0;
    logic nz_mode = 1'b0;
    logic abort = 1'b0;
    logic [3:0] lbusy = 4'h0;
    logic [7:0] pbytes [64];
    logic [8:0] exp_q [4][$];
    logic [3:0] start_q [$];
    logic       mode_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pkt_ready"}, 32'(bus.pkt_ready), 32'd0);
        check({tag, "_start"},     32'(bus.lane_start_rqst), 32'd0);
        check({tag, "_fin"},       32'(bus.lane_fin_rqst), 32'd0);
        check({tag, "_data"},      bus.lane_data, 32'd0);
        check({tag, "_mode_lp"},   32'(bus.lane_mode_lp), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_underrun"},  32'(underrun), 32'd0);
    endtask

    // Lane request pattern: every cycle, or one cycle in rq_period.
    initial begin
        bus.lane_data_rqst = 4'h0;
        forever begin
            @(posedge clk_sys); #1;
            cyc++;
            bus.lane_data_rqst = (rq_period <= 1 || (cyc % rq_period) == 0) ? 4'hF : 4'h0;
        end
    end

    // Monitor and lane model: pops are evaluated before this cycle's start pulse takes effect.
    initial begin
        logic [8:0] act, e;
        bus.lane_active = 4'h0;
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) exp_q[k].delete();
                start_q.delete();
                mode_q.delete();
                lbusy = 4'h0;
                bus.lane_active = 4'h0;
                continue;
            end
            for (int k = 0; k < 4; k++) begin
                if (bus.lane_data_rqst[k] && lbusy[k]) begin
                    act = {bus.lane_fin_rqst[k], bus.lane_data[8*k +: 8]};
                    if (nz_mode && act == 9'h000) begin
                        // lane starved: nothing popped this cycle
                    end else if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lane%0d_extra_byte: got %0h expected nothing", k, act);
                    end else begin
                        e = exp_q[k].pop_front();
                        check($sformatf("lane%0d_byte", k), 32'(act), 32'(e));
                        if (e[8]) begin
                            lbusy[k] = 1'b0;
                            bus.lane_active[k] = 1'b0;
                        end
                    end
                end
            end
            if (bus.lane_start_rqst != 4'h0) begin
                if (start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_start: got %0h expected none", bus.lane_start_rqst);
                end else begin
                    check("start_mask", 32'(bus.lane_start_rqst), 32'(start_q.pop_front()));
                    check("start_mode_lp", 32'(bus.lane_mode_lp), 32'(mode_q.pop_front()));
                end
                lbusy = lbusy | bus.lane_start_rqst;
                bus.lane_active = bus.lane_active | bus.lane_start_rqst;
            end
        end
    end

    // Sends one packet from pbytes; lanes_number is scrambled after the first word.
    task automatic send_pkt(input int len, input int n_m1, input logic lp,
                            input int gap_after, input int gap_len);
        int n, nwords, t;
        logic accepted;
        logic [7:0] b [4];
        n = lp ? 1 : n_m1 + 1;
        for (int i = 0; i < len; i++)
            exp_q[i % n].push_back({(i >= len - n), pbytes[i]});
        start_q.push_back(lp ? 4'b0001 : 4'((5'd2 << n_m1) - 5'd1));
        mode_q.push_back(lp);
        nwords = (len + 3) / 4;
        stall_cnt = 0;
        for (int w = 0; w < nwords; w++) begin
            if (w == gap_after) begin
                bus.pkt_valid = 1'b0;
                repeat (gap_len) @(posedge clk_sys);
                #1;
            end
            for (int j = 0; j < 4; j++) b[j] = (4*w + j < len) ? pbytes[4*w + j] : 8'h00;
            bus.pkt_valid    = 1'b1;
            bus.pkt_data     = {b[3], b[2], b[1], b[0]};
            bus.pkt_last     = (w == nwords - 1);
            bus.pkt_bytes    = (w == nwords - 1) ? 2'(len - 1 - 4*w) : 2'd3;
            bus.pkt_mode_lp  = lp;
            bus.lanes_number = (w == 0) ? 2'(n_m1) : ~2'(n_m1);
            accepted = 1'b0;
            t = 0;
            while (!accepted) begin
                @(negedge clk_sys);
                accepted = bus.pkt_ready;
                if (!accepted && w > 0) stall_cnt++;
                @(posedge clk_sys); #1;
                if (abort) begin
                    bus.pkt_valid = 1'b0;
                    return;
                end
                t++;
                if (t > 3000) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake_timeout: word %0d never accepted", w);
                    bus.pkt_valid = 1'b0;
                    return;
                end
            end
        end
        bus.pkt_valid = 1'b0;
        bus.pkt_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        forever begin
            @(negedge clk_sys);
            if (!busy && exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0
                && exp_q[3].size() == 0 && start_q.size() == 0) break;
            t++;
            if (t > 4000) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: busy=%0d never returned to idle", name, busy);
                break;
            end
        end
        @(posedge clk_sys); #1;
    endtask

    initial begin
        bus.pkt_valid    = 1'b0;
        bus.pkt_data     = '0;
        bus.pkt_last     = 1'b0;
        bus.pkt_bytes    = '0;
        bus.pkt_mode_lp  = 1'b0;
        bus.lanes_number = '0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk_sys); #1;

        // 4 lanes HS, 8 bytes
        for (int i = 0; i < 64; i++) pbytes[i] = 8'(i);
        send_pkt(8, 3, 1'b0, -1, 0);
        wait_idle("hs4x8");
        check("hs4x8_underrun", 32'(underrun), 32'd0);

        // 2 lanes HS, 6 bytes
        send_pkt(6, 1, 1'b0, -1, 0);
        wait_idle("hs2x6");

        // LP with lanes_number=3, 5 bytes: lane 0 only
        send_pkt(5, 3, 1'b1, -1, 0);
        wait_idle("lp5");
        check("lp5_mode_held", 32'(bus.lane_mode_lp), 32'd1);

        // Back-pressure: lanes request once every 8 cycles, 64 bytes
        rq_period = 8;
        send_pkt(64, 3, 1'b0, -1, 0);
        check("bp_ready_low", 32'(stall_cnt > 0), 32'd1);
        wait_idle("bp64");
        check("bp64_underrun", 32'(underrun), 32'd0);

        // Starved source on 2 lanes, nonzero bytes so an empty lane reads as 0
        rq_period = 1;
        nz_mode = 1'b1;
        for (int i = 0; i < 64; i++) pbytes[i] = 8'(i + 1);
        send_pkt(24, 1, 1'b0, 3, 40);
        wait_idle("starve");
        check("starve_underrun_set", 32'(underrun), 32'd1);
        nz_mode = 1'b0;

        for (int i = 0; i < 64; i++) pbytes[i] = 8'(i);
        send_pkt(8, 3, 1'b0, -1, 0);
        wait_idle("after_starve");
        check("underrun_cleared", 32'(underrun), 32'd0);

        // Reset asserted mid-STREAM
        rq_period = 8;
        fork
            send_pkt(64, 3, 1'b0, -1, 0);
        join_none
        repeat (60) @(posedge clk_sys);
        #3;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk_sys);
        #2;
        abort = 1'b0;
        bus.pkt_valid = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        rq_period = 1;
        @(posedge clk_sys); #1;
        for (int i = 0; i < 64; i++) pbytes[i] = 8'(8'h40 + i);
        send_pkt(8, 3, 1'b0, -1, 0);
        wait_idle("post_reset");
        check("post_reset_underrun", 32'(underrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
